// File: rtl/x68k_ldr_pkg.sv
// Shared types and constants for the X68K loader sink.
package x68k_ldr_pkg;

    // Loader byte address width and the matching 16-bit word index width.
    localparam int LDR_AW  = 20;
    localparam int LDR_WAW = LDR_AW - 1;

    // Byte-enable patterns: [1] = even/high byte, [0] = odd/low byte.
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

    // Top-level handshake state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } ldr_state_t;

    // Decision taken in IDLE for the current cycle.
    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,  // nothing to do
        ACT_CAPTURE = 3'd1,  // even byte parked in the hold buffer
        ACT_WORD    = 3'd2,  // held even byte + current odd byte
        ACT_LO      = 3'd3,  // lone odd byte
        ACT_FLUSH   = 3'd4   // held even byte written on its own
    } ldr_act_t;

    // Number of bytes a write with this byte-enable commits.
    function automatic logic [1:0] be_popcount(input logic [1:0] be);
        return {1'b0, be[1]} + {1'b0, be[0]};
    endfunction

endpackage

// File: rtl/x68k_ldr_sink.sv
// Loader sink: pairs loader bytes into big-endian 16-bit words and issues
// them to a memory write port, acknowledging the loader once each byte is
// either buffered or written.
module x68k_ldr_sink
    import x68k_ldr_pkg::*;
#(
    parameter int             MAW      = 23,
    parameter logic [MAW-1:0] MEM_BASE = '0
) (
    input  logic              sysclk,
    input  logic              rstn,
    input  logic [LDR_AW-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdat,
    input  logic              ldr_aen,
    input  logic              ldr_wr,
    output logic              ldr_ack,
    output logic [MAW-1:0]    mem_addr,
    output logic [15:0]       mem_wdat,
    output logic [1:0]        mem_be,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              busy,
    output logic [LDR_AW-1:0] byte_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ldr_state_t          r_state;
    logic                r_ack_after;   // WRITE ends in ACK (1) or IDLE (0)
    logic                r_hold_valid;
    logic [LDR_WAW-1:0]  r_hold_waddr;
    logic [7:0]          r_hold_byte;
    logic                r_aen_d;       // previous ldr_aen, for edge detect
    logic                r_flush_pend;  // ldr_aen fell while not in IDLE
    logic                r_ldr_ack;
    logic                r_mem_wr;
    logic [MAW-1:0]      r_mem_addr;
    logic [15:0]         r_mem_wdat;
    logic [1:0]          r_mem_be;
    logic [LDR_AW-1:0]   r_byte_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                w_req;
    logic                w_req_odd;
    logic [LDR_WAW-1:0]  w_req_waddr;
    logic                w_aen_fall;
    logic                w_pair_match;
    logic                w_flush_aen;
    logic                w_wr_done;
    logic                w_issue;
    ldr_act_t            w_act;
    logic [LDR_WAW-1:0]  w_issue_waddr;
    logic [15:0]         w_issue_wdat;
    logic [1:0]          w_issue_be;
    logic [LDR_AW:0]     w_cnt_sum;

    // ldr_ack is still high while the initiator drops ldr_wr, so masking
    // with it prevents the same byte from being taken twice.
    assign w_req        = ldr_aen & ldr_wr & ~r_ldr_ack;
    assign w_req_odd    = ldr_addr[0];
    assign w_req_waddr  = ldr_addr[LDR_AW-1:1];
    assign w_aen_fall   = r_aen_d & ~ldr_aen;
    assign w_pair_match = w_req_odd & r_hold_valid & (r_hold_waddr == w_req_waddr);
    // A pending session end (seen now or latched earlier) only matters
    // when there is a byte to push out.
    assign w_flush_aen  = r_hold_valid & (w_aen_fall | r_flush_pend);
    assign w_wr_done    = (r_state == WRITE) & mem_ack;
    assign w_issue      = (w_act == ACT_WORD) | (w_act == ACT_LO) | (w_act == ACT_FLUSH);

    // Choose what IDLE does this cycle; the session-end flush wins over a request.
    always_comb begin
        w_act = ACT_NONE;
        if (r_state == IDLE) begin
            if (w_flush_aen) begin
                w_act = ACT_FLUSH;
            end else if (w_req) begin
                if (w_pair_match) begin
                    w_act = ACT_WORD;
                end else if (r_hold_valid) begin
                    // Request stays pending and is re-evaluated after the flush.
                    w_act = ACT_FLUSH;
                end else if (w_req_odd) begin
                    w_act = ACT_LO;
                end else begin
                    w_act = ACT_CAPTURE;
                end
            end
        end
    end

    // Assemble the word address, data and byte enables for the write being issued.
    always_comb begin
        w_issue_waddr = w_req_waddr;
        w_issue_wdat  = {8'h00, ldr_wdat};
        w_issue_be    = BE_LO;
        case (w_act)
            ACT_WORD: begin
                w_issue_wdat = {r_hold_byte, ldr_wdat};
                w_issue_be   = BE_WORD;
            end
            ACT_FLUSH: begin
                w_issue_waddr = r_hold_waddr;
                w_issue_wdat  = {r_hold_byte, 8'h00};
                w_issue_be    = BE_HI;
            end
            default: begin
            end
        endcase
    end

    // Saturating byte counter increment; the extra top bit flags overflow.
    assign w_cnt_sum = {1'b0, r_byte_cnt} + {{(LDR_AW-1){1'b0}}, be_popcount(r_mem_be)};

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM: IDLE decides, WRITE waits for mem_ack, ACK waits for ldr_wr to drop.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_ack_after <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state     <= WRITE;
                        r_ack_after <= (w_act != ACT_FLUSH);
                    end else if (w_act == ACT_CAPTURE) begin
                        r_state <= ACK;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        r_state <= r_ack_after ? ACK : IDLE;
                    end
                end
                ACK: begin
                    if (!ldr_wr) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Loader acknowledge: raised on entry to ACK, dropped once ldr_wr is seen low.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_ldr_ack <= 1'b0;
        end else if (w_act == ACT_CAPTURE) begin
            r_ldr_ack <= 1'b1;
        end else if (w_wr_done && r_ack_after) begin
            r_ldr_ack <= 1'b1;
        end else if (r_state == ACK && !ldr_wr) begin
            r_ldr_ack <= 1'b0;
        end
    end

    // Memory write request: set on issue, cleared on the mem_ack edge.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_mem_wr <= 1'b0;
        end else if (w_issue) begin
            r_mem_wr <= 1'b1;
        end else if (w_wr_done) begin
            r_mem_wr <= 1'b0;
        end
    end

    // Memory address/data/enables, frozen for the whole WRITE phase.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_mem_addr <= '0;
            r_mem_wdat <= '0;
            r_mem_be   <= '0;
        end else if (w_issue) begin
            r_mem_addr <= MEM_BASE + MAW'(w_issue_waddr);
            r_mem_wdat <= w_issue_wdat;
            r_mem_be   <= w_issue_be;
        end
    end

    // Hold buffer: parks an even byte until its odd partner or a flush.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_hold_valid <= 1'b0;
            r_hold_waddr <= '0;
            r_hold_byte  <= '0;
        end else if (w_act == ACT_CAPTURE) begin
            r_hold_valid <= 1'b1;
            r_hold_waddr <= w_req_waddr;
            r_hold_byte  <= ldr_wdat;
        end else if (w_act == ACT_WORD || w_act == ACT_FLUSH) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Session-end tracking: latch an ldr_aen fall seen outside IDLE.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_aen_d      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_aen_d <= ldr_aen;
            if (r_state == IDLE) begin
                // IDLE acts on the fall directly (or had nothing to flush).
                r_flush_pend <= 1'b0;
            end else if (w_aen_fall) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Committed byte count, saturating at all-ones.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_byte_cnt <= '0;
        end else if (w_wr_done) begin
            r_byte_cnt <= w_cnt_sum[LDR_AW] ? {LDR_AW{1'b1}} : w_cnt_sum[LDR_AW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ldr_ack  = r_ldr_ack;
    assign mem_wr   = r_mem_wr;
    assign mem_addr = r_mem_addr;
    assign mem_wdat = r_mem_wdat;
    assign mem_be   = r_mem_be;
    assign byte_cnt = r_byte_cnt;
    assign busy     = (r_state != IDLE) | r_hold_valid;

endmodule

// File: tb/tb_x68k_ldr_sink.sv
// Self-checking bench for x68k_ldr_sink: directed scenarios plus random
// loader traffic, checked against a byte-pairing reference model.
module tb_x68k_ldr_sink;

    localparam logic [22:0] BASE      = 23'h000100;
    localparam logic [22:0] WRAP_BASE = 23'h7FFFFF;

    logic        sysclk;
    logic        rstn;
    logic [19:0] ldr_addr;
    logic [7:0]  ldr_wdat;
    logic        ldr_aen;
    logic        ldr_wr;
    logic        mem_ack;
    logic        arb_ack;
    logic        spur_ack;

    logic        ldr_ack,  w_ldr_ack;
    logic [22:0] mem_addr, w_mem_addr;
    logic [15:0] mem_wdat, w_mem_wdat;
    logic [1:0]  mem_be,   w_mem_be;
    logic        mem_wr,   w_mem_wr;
    logic        busy,     w_busy;
    logic [19:0] byte_cnt, w_byte_cnt;

    assign mem_ack = arb_ack | spur_ack;

    x68k_ldr_sink #(.MAW(23), .MEM_BASE(BASE)) u_dut (
        .sysclk(sysclk), .rstn(rstn),
        .ldr_addr(ldr_addr), .ldr_wdat(ldr_wdat), .ldr_aen(ldr_aen), .ldr_wr(ldr_wr),
        .ldr_ack(ldr_ack),
        .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_be(mem_be), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .busy(busy), .byte_cnt(byte_cnt)
    );

    // Second instance with a base that wraps the word address space.
    x68k_ldr_sink #(.MAW(23), .MEM_BASE(WRAP_BASE)) u_dut_wrap (
        .sysclk(sysclk), .rstn(rstn),
        .ldr_addr(ldr_addr), .ldr_wdat(ldr_wdat), .ldr_aen(ldr_aen), .ldr_wr(ldr_wr),
        .ldr_ack(w_ldr_ack),
        .mem_addr(w_mem_addr), .mem_wdat(w_mem_wdat), .mem_be(w_mem_be), .mem_wr(w_mem_wr),
        .mem_ack(mem_ack), .busy(w_busy), .byte_cnt(w_byte_cnt)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // ---------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: expected memory writes in issue order
    // ---------------------------------------------------------------
    typedef struct packed {
        logic [18:0] waddr;
        logic [15:0] wdat;
        logic [1:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    logic        m_hold_valid = 1'b0;
    logic [18:0] m_hold_waddr = '0;
    logic [7:0]  m_hold_byte  = '0;
    int          m_cnt        = 0;
    int          n_writes     = 0;
    int          n_acks       = 0;
    int          ack_delay    = 1;

    // Held even byte written alone.
    task automatic model_flush();
        if (m_hold_valid) begin
            exp_q.push_back('{waddr: m_hold_waddr, wdat: {m_hold_byte, 8'h00}, be: 2'b10});
            m_hold_valid = 1'b0;
        end
    endtask

    // One loader byte: an odd byte completes a word with the held even
    // byte of the same word; anything else held gets flushed first.
    task automatic model_byte(input logic [19:0] a, input logic [7:0] d);
        logic [18:0] wa;
        logic        paired;
        wa     = a[19:1];
        paired = a[0] && m_hold_valid && (m_hold_waddr == wa);
        if (!paired) model_flush();
        if (!a[0]) begin
            m_hold_valid = 1'b1;
            m_hold_waddr = wa;
            m_hold_byte  = d;
        end else if (paired) begin
            exp_q.push_back('{waddr: wa, wdat: {m_hold_byte, d}, be: 2'b11});
            m_hold_valid = 1'b0;
        end else begin
            exp_q.push_back('{waddr: wa, wdat: {8'h00, d}, be: 2'b01});
        end
    endtask

    // ---------------------------------------------------------------
    // Arbiter: acks each write ack_delay cycles after it is seen, checks
    // stability meanwhile and compares the completed write to the model.
    // ---------------------------------------------------------------
    initial begin : arbiter
        wr_t         e;
        logic [22:0] ca;
        logic [15:0] cw;
        logic [1:0]  cb;
        logic [22:0] ea;
        bit          aborted;
        arb_ack = 1'b0;
        forever begin
            @(negedge sysclk);
            if (rstn && mem_wr) begin
                ca = mem_addr;
                cw = mem_wdat;
                cb = mem_be;
                check("wrap_wr_sync", w_mem_wr, 1);
                aborted = 1'b0;
                for (int k = 0; k < ack_delay; k++) begin
                    @(posedge sysclk); #1;
                    if (!rstn) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("wr_held", mem_wr, 1);
                    check("addr_stable", mem_addr, ca);
                    check("wdat_stable", mem_wdat, cw);
                    check("be_stable", mem_be, cb);
                    check("no_ack_in_write", ldr_ack, 0);
                end
                if (!aborted) begin
                    arb_ack = 1'b1;
                    @(posedge sysclk); #1;
                    arb_ack = 1'b0;
                    check("wr_drop_on_ack", mem_wr, 0);
                    check("write_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e  = exp_q.pop_front();
                        ea = BASE + 23'(e.waddr);
                        check("mem_addr", ca, ea);
                        ea = WRAP_BASE + 23'(e.waddr);
                        check("wrap_addr", w_mem_addr, ea);
                        check("mem_wdat", cw, e.wdat);
                        check("mem_be", cb, e.be);
                        m_cnt += $countones(e.be);
                        check("byte_cnt", byte_cnt, m_cnt);
                        check("wrap_byte_cnt", w_byte_cnt, m_cnt);
                        $display("write addr=%06h wdat=%04h be=%02b cnt=%0d", ca, cw, cb, byte_cnt);
                    end
                    n_writes++;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Loader driver
    // ---------------------------------------------------------------
    task automatic send_byte(input logic [19:0] a, input logic [7:0] d, input int hold,
                             input bit drop_in_ack, output int lat);
        model_byte(a, d);
        ldr_addr = a;
        ldr_wdat = d;
        ldr_wr   = 1'b1;
        lat      = 0;
        while (!ldr_ack && lat < 200) begin
            @(posedge sysclk); #1;
            lat++;
        end
        check("ack_rise", ldr_ack, 1);
        n_acks++;
        if (drop_in_ack) begin
            model_flush();
            ldr_aen = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge sysclk); #1;
            check("ack_held", ldr_ack, 1);
        end
        ldr_wr = 1'b0;
        @(posedge sysclk); #1;
        check("ack_fall", ldr_ack, 0);
        $display("txn addr=%05h data=%02h lat=%0d hold=%0d drop=%0d", a, d, lat, hold, drop_in_ack);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge sysclk); #1;
        end
        repeat (2) @(posedge sysclk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic drop_aen_idle();
        model_flush();
        ldr_aen = 1'b0;
        wait_drain();
        check("busy_after_flush", busy, 0);
        ldr_aen = 1'b1;
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin : main
        int          lat;
        int          exp_lat;
        int          w0;
        int          a0;
        logic [19:0] a;
        logic [19:0] last_a;
        logic [7:0]  d;
        int          r;
        bit          dropk;

        rstn = 1'b0; ldr_addr = '0; ldr_wdat = '0; ldr_aen = 1'b0; ldr_wr = 1'b0;
        spur_ack = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_mem_wr", mem_wr, 0);
        check("rst_ldr_ack", ldr_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdat", mem_wdat, 0);
        check("rst_mem_be", mem_be, 0);
        rstn = 1'b1;
        @(posedge sysclk); #1;
        ldr_aen = 1'b1;
        @(posedge sysclk); #1;

        // Even then odd of the same word: one full-word write.
        a0 = n_acks;
        send_byte(20'h00000, 8'hAA, 0, 1'b0, lat);
        check("lat_even_buffered", lat, 1);
        check("busy_holding", busy, 1);
        send_byte(20'h00001, 8'h55, 0, 1'b0, lat);
        check("lat_paired_odd", lat, 3);
        check("t1_acks", n_acks - a0, 2);
        check("t1_cnt", byte_cnt, 2);

        // Lone odd byte.
        send_byte(20'h00003, 8'h12, 0, 1'b0, lat);
        check("lat_lone_odd", lat, 3);

        // Two evens: flush of the first happens before the second is acked.
        send_byte(20'h00004, 8'h34, 0, 1'b0, lat);
        w0 = n_writes;
        send_byte(20'h00006, 8'h56, 0, 1'b0, lat);
        check("flush_before_ack", n_writes - w0, 1);
        check("busy_56_held", busy, 1);

        // Even byte then session end (also flushes 8'h56 first).
        send_byte(20'h00008, 8'h9A, 0, 1'b0, lat);
        drop_aen_idle();

        // Slow arbiter and a long ldr_wr hold.
        ack_delay = 10;
        send_byte(20'h0000B, 8'h77, 5, 1'b0, lat);
        ack_delay = 1;

        // A request with the session inactive is ignored.
        ldr_aen = 1'b0; ldr_addr = 20'h00020; ldr_wdat = 8'hEE; ldr_wr = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 6; i++) begin
            @(posedge sysclk); #1;
            check("aen_low_no_ack", ldr_ack, 0);
        end
        check("aen_low_busy", busy, 0);
        check("aen_low_no_write", n_writes - w0, 0);
        ldr_wr = 1'b0; ldr_aen = 1'b1;
        @(posedge sysclk); #1;

        // Stray mem_ack while idle.
        spur_ack = 1'b1;
        @(posedge sysclk); #1;
        spur_ack = 1'b0;
        @(posedge sysclk); #1;
        check("spur_ack_cnt", byte_cnt, m_cnt);
        check("spur_ack_wr", mem_wr, 0);

        // Word 1 on the wrapping instance lands at address 0.
        send_byte(20'h00002, 8'hC3, 0, 1'b0, lat);
        send_byte(20'h00003, 8'h3C, 0, 1'b0, lat);
        check("wrap_to_zero", w_mem_addr, 23'h000000);

        // Session end while in ACK: flushed on return to IDLE.
        send_byte(20'h00040, 8'h61, 2, 1'b1, lat);
        wait_drain();
        check("busy_after_ack_drop", busy, 0);
        ldr_aen = 1'b1;

        // Random traffic.
        last_a = 20'h00040;
        for (int t = 0; t < 80; t++) begin
            ack_delay = $urandom_range(1, 4);
            r = $urandom_range(0, 9);
            if (r < 5) a = last_a | 20'h00001;
            else       a = 20'($urandom_range(0, 20'hFFFFF));
            d     = 8'($urandom);
            dropk = ($urandom_range(0, 9) == 0);
            exp_lat = 0;
            if (!a[0] && !m_hold_valid) exp_lat = 1;
            else if (a[0] && ack_delay == 1 && (!m_hold_valid || m_hold_waddr == a[19:1])) exp_lat = 3;
            send_byte(a, d, $urandom_range(0, 3), dropk, lat);
            if (exp_lat != 0) check("rand_latency", lat, exp_lat);
            if (dropk) begin
                wait_drain();
                check("rand_busy_after_drop", busy, 0);
                ldr_aen = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                drop_aen_idle();
            end
            last_a = 20'($urandom_range(0, 20'hFFFFF)) & 20'hFFFFE;
            if ($urandom_range(0, 1) == 1) last_a = a & 20'hFFFFE;
        end
        ack_delay = 1;
        drop_aen_idle();

        // Reset in the middle of a write.
        send_byte(20'h00100, 8'h11, 0, 1'b0, lat);
        ack_delay = 20;
        ldr_addr = 20'h00203; ldr_wdat = 8'h22; ldr_wr = 1'b1;
        for (int i = 0; i < 50 && !mem_wr; i++) begin
            @(posedge sysclk); #1;
        end
        check("rst_test_wr_started", mem_wr, 1);
        repeat (3) @(posedge sysclk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_mem_wr", mem_wr, 0);
        check("midrst_ldr_ack", ldr_ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_byte_cnt", byte_cnt, 0);
        exp_q.delete();
        m_hold_valid = 1'b0;
        m_cnt        = 0;
        ldr_wr = 1'b0; ldr_aen = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        rstn = 1'b1;
        ack_delay = 1;
        w0 = n_writes;
        ldr_aen = 1'b1;
        repeat (20) @(posedge sysclk);
        #1;
        check("post_rst_no_write", n_writes - w0, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_cnt", byte_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
